// File: rtl/boss_pkg.sv
// -----------------------------------------------------------------------------
// boss_pkg
// Shared definitions for the boss controller: FSM state encoding, spawn point,
// per-phase waypoints and the phase encoding driven onto the `phase` output.
// Helper functions map a state to its phase code and waypoint coordinates.
// -----------------------------------------------------------------------------
package boss_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        P3   = 3'd3,
        DEAD = 3'd4
    } boss_state_t;

    localparam int SPAWN_X = 0;
    localparam int SPAWN_Y = 75;

    localparam int WP1_X = 220;
    localparam int WP1_Y = 75;
    localparam int WP2_X = 220;
    localparam int WP2_Y = 240;
    localparam int WP3_X = 440;
    localparam int WP3_Y = 240;

    localparam logic [1:0] PH_NONE = 2'd0;
    localparam logic [1:0] PH_1    = 2'd1;
    localparam logic [1:0] PH_2    = 2'd2;
    localparam logic [1:0] PH_3    = 2'd3;

    function automatic logic [1:0] phase_of(input boss_state_t s);
        case (s)
            P1:      return PH_1;
            P2:      return PH_2;
            P3:      return PH_3;
            default: return PH_NONE;
        endcase
    endfunction

    function automatic int wp_x(input boss_state_t s);
        case (s)
            P2:      return WP2_X;
            P3:      return WP3_X;
            default: return WP1_X;
        endcase
    endfunction

    function automatic int wp_y(input boss_state_t s);
        case (s)
            P2:      return WP2_Y;
            P3:      return WP3_Y;
            default: return WP1_Y;
        endcase
    endfunction

endpackage

// File: rtl/boss_axis_step.sv
// -----------------------------------------------------------------------------
// boss_axis_step
// One axis of boss movement. On a tick the position steps STEP pixels toward
// the target, snapping onto it when within STEP, so it never overshoots or
// wraps. The distance is formed at W+1 bits so its sign is explicit.
// Ports:
//   pos       - current coordinate
//   target    - waypoint coordinate for this axis
//   tick      - move strobe
//   next_pos  - coordinate after this cycle's (possible) step
//   at_target - pos currently equals target
// -----------------------------------------------------------------------------
module boss_axis_step #(
    parameter int W    = 10,
    parameter int STEP = 1
) (
    input  logic [W-1:0] pos,
    input  logic [W-1:0] target,
    input  logic         tick,
    output logic [W-1:0] next_pos,
    output logic         at_target
);

    localparam logic [W:0] L_STEP = (W+1)'(STEP);

    function automatic logic [W:0] abs_dist(input logic signed [W:0] d);
        return d[W] ? $unsigned(-d) : $unsigned(d);
    endfunction

    logic signed [W:0] w_diff;
    logic [W:0]        w_mag;

    always_comb begin
        w_diff   = $signed({1'b0, target}) - $signed({1'b0, pos});
        w_mag    = abs_dist(w_diff);
        next_pos = pos;
        if (tick) begin
            if (w_mag <= L_STEP) begin
                next_pos = target;
            end else if (w_diff[W]) begin
                next_pos = pos - W'(STEP);
            end else begin
                next_pos = pos + W'(STEP);
            end
        end
        at_target = (pos == target);
    end

endmodule

// File: rtl/boss_path.sv
// -----------------------------------------------------------------------------
// boss_path
// Boss controller: spawns the boss when every enemy slot is clear and HP is in
// range, walks it toward a per-phase waypoint at a programmable rate, and
// advances phases monotonically as HP falls below TH1/TH2. HP of zero kills
// the boss, which then stays dead until reset.
// Optional feature macro: BOSS_FLASH_EN (hit flash of FLASH_CYC cycles).
// Ports:
//   clk22   - game clock
//   rst     - asynchronous active-high reset
//   enm     - enemy-alive flags, one per slot
//   bosshp  - current boss HP
//   bossx/y - boss sprite position (registered)
//   boss    - boss active/visible (registered)
//   phase   - 0 none, 1..3 current phase (registered)
//   arrived - position equalled the active waypoint last cycle (registered)
//   flash   - hit flash (constant 0 without BOSS_FLASH_EN)
// -----------------------------------------------------------------------------
module boss_path
    import boss_pkg::*;
#(
    parameter int W         = 10,
    parameter int HP_W      = 10,
    parameter int N_ENM     = 4,
    parameter int HP_MAX    = 450,
    parameter int TH1       = 300,
    parameter int TH2       = 150,
    parameter int STEP      = 1,
    parameter int MOVE_DIV  = 1,
    parameter int FLASH_CYC = 8
) (
    input  logic             clk22,
    input  logic             rst,
    input  logic [N_ENM-1:0] enm,
    input  logic [HP_W-1:0]  bosshp,
    output logic [W-1:0]     bossx,
    output logic [W-1:0]     bossy,
    output logic             boss,
    output logic [1:0]       phase,
    output logic             arrived,
    output logic             flash
);

    localparam logic [HP_W-1:0] L_HP_MAX = HP_W'(HP_MAX);
    localparam logic [HP_W-1:0] L_TH1    = HP_W'(TH1);
    localparam logic [HP_W-1:0] L_TH2    = HP_W'(TH2);
    localparam int              DIV_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [DIV_W-1:0] L_DIV_LAST = DIV_W'(MOVE_DIV - 1);

    boss_state_t      r_state;
    boss_state_t      w_state_nxt;
    logic [W-1:0]     r_x, r_y;
    logic [W-1:0]     w_tgt_x, w_tgt_y;
    logic [W-1:0]     w_x_step, w_y_step;
    logic             w_at_x, w_at_y;
    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    logic             w_spawn;
    logic             w_active_nxt;
    logic             r_boss;
    logic [1:0]       r_phase;
    logic             r_arrived;

    // Next-state: phases only move forward; P3 can be reached straight from P1.
    always_comb begin
        w_spawn     = (enm == '0) && (bosshp != '0) && (bosshp <= L_HP_MAX);
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_spawn) begin
                    w_state_nxt = P1;
                end
            end
            P1, P2, P3: begin
                if (bosshp == '0) begin
                    w_state_nxt = DEAD;
                end else if (bosshp <= L_TH2) begin
                    w_state_nxt = P3;
                end else if ((bosshp <= L_TH1) && (r_state == P1)) begin
                    w_state_nxt = P2;
                end
            end
            default: w_state_nxt = r_state;
        endcase
        w_active_nxt = (w_state_nxt == P1) || (w_state_nxt == P2) || (w_state_nxt == P3);
        // Target follows the next state so a tick coinciding with a phase
        // change already steps toward the new waypoint.
        w_tgt_x = W'(wp_x(w_state_nxt));
        w_tgt_y = W'(wp_y(w_state_nxt));
        w_tick  = (r_div == L_DIV_LAST);
    end

    boss_axis_step #(.W(W), .STEP(STEP)) u_step_x (
        .pos       (r_x),
        .target    (w_tgt_x),
        .tick      (w_tick),
        .next_pos  (w_x_step),
        .at_target (w_at_x)
    );

    boss_axis_step #(.W(W), .STEP(STEP)) u_step_y (
        .pos       (r_y),
        .target    (w_tgt_y),
        .tick      (w_tick),
        .next_pos  (w_y_step),
        .at_target (w_at_y)
    );

    // State, position, divider and registered outputs.
    always_ff @(posedge clk22 or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_x       <= W'(SPAWN_X);
            r_y       <= W'(SPAWN_Y);
            r_div     <= '0;
            r_boss    <= 1'b0;
            r_phase   <= PH_NONE;
            r_arrived <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_boss    <= w_active_nxt;
            r_phase   <= phase_of(w_state_nxt);
            r_arrived <= w_active_nxt && (r_state != IDLE) && w_at_x && w_at_y;
            if (r_state == IDLE) begin
                if (w_spawn) begin
                    r_x   <= W'(SPAWN_X);
                    r_y   <= W'(SPAWN_Y);
                    r_div <= '0;
                end
            end else if (w_state_nxt == DEAD) begin
                r_x   <= '0;
                r_y   <= '0;
                r_div <= '0;
            end else begin
                r_x   <= w_x_step;
                r_y   <= w_y_step;
                r_div <= w_tick ? '0 : (r_div + DIV_W'(1));
            end
        end
    end

    assign bossx   = r_x;
    assign bossy   = r_y;
    assign boss    = r_boss;
    assign phase   = r_phase;
    assign arrived = r_arrived;

`ifdef BOSS_FLASH_EN
    localparam int FL_W = $clog2(FLASH_CYC + 1);

    logic [HP_W-1:0] r_hp_prev;
    logic [FL_W-1:0] r_fcnt;
    logic            r_flash;

    // Counter holds the remaining flash cycles after the current one; a new
    // hit reloads it so the flash always lasts FLASH_CYC cycles past the hit.
    always_ff @(posedge clk22 or posedge rst) begin
        if (rst) begin
            r_hp_prev <= '0;
            r_fcnt    <= '0;
            r_flash   <= 1'b0;
        end else begin
            r_hp_prev <= bosshp;
            if (w_state_nxt == DEAD) begin
                r_fcnt  <= '0;
                r_flash <= 1'b0;
            end else if (((r_state == P1) || (r_state == P2) || (r_state == P3))
                         && (bosshp < r_hp_prev)) begin
                r_fcnt  <= FL_W'(FLASH_CYC - 1);
                r_flash <= 1'b1;
            end else if (r_fcnt != '0) begin
                r_fcnt  <= r_fcnt - FL_W'(1);
                r_flash <= 1'b1;
            end else begin
                r_flash <= 1'b0;
            end
        end
    end

    assign flash = r_flash;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (FLASH_CYC != 0);
    assign flash        = 1'b0;
`endif

endmodule

// File: doc/boss_path.md
# boss_path

Parametrised boss controller for the shooter game, the successor to the fixed three-stage boss mover. It spawns the boss once all enemy wave slots are clear and HP is valid. It then steps the boss toward a per-phase waypoint at a programmable rate and advances phases monotonically as `bosshp` crosses configurable thresholds. Outputs feed the VGA sprite renderer and the bullet/collision logic.

## Interface
- `W`, default 10: coordinate width for `bossx`/`bossy`.
- `HP_W`, default 10: width of `bosshp`.
- `N_ENM`, default 4: number of enemy-alive inputs.
- `HP_MAX`, default 450: spawn allowed only when 0 < `bosshp` ≤ `HP_MAX`.
- `TH1`, default 300; `TH2`, default 150: phase thresholds. Require `TH1` > `TH2` > 0.
- `STEP`, default 1: pixels moved per axis per move tick. Must be ≥ 1.
- `MOVE_DIV`, default 1: clock cycles per move tick. Must be ≥ 1.
- `FLASH_CYC`, default 8: hit-flash length in cycles. Used only with `BOSS_FLASH_EN`.
- `clk22`, input, 1: game clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `enm`, input, `N_ENM`: enemy-alive flags, one per slot.
- `bosshp`, input, `HP_W`: current boss HP. Driven by the damage logic.
- `bossx`, `bossy`, output, `W` each: boss sprite position.
- `boss`, output, 1: boss active/visible.
- `phase`, output, 2: 0 = none, 1/2/3 = current phase.
- `arrived`, output, 1: position equals the current phase waypoint.
- `flash`, output, 1: hit flash. Tied to 0 when the macro is off.

## Operation
- FSM states: IDLE, P1, P2, P3, DEAD. Held in IDLE while `rst` is high.
- IDLE → P1: when `enm` == 0 and 0 < `bosshp` ≤ `HP_MAX`. Evaluated every cycle. On this transition the position loads the spawn point (`SPAWN_X`, `SPAWN_Y`).
- Phase advance from any active state:
  - `bosshp` == 0 → DEAD.
  - Else `bosshp` ≤ `TH2` → P3.
  - Else `bosshp` ≤ `TH1` → P2.
  - Phases only advance, never regress, even if HP rises.
  - Skipping is allowed, e.g. P1 → P3 on one large hit.
- Once active, `enm` is ignored; a new enemy wave does not despawn the boss.
- DEAD: `boss` = 0, `phase` = 0, position = (0,0). Held until `rst`.
- Movement, on each move tick in P1–P3, applied to each axis independently:
  - If |target − pos| ≤ `STEP`, set pos = target.
  - Otherwise pos moves `STEP` toward the target.
  - No overshoot and no wrap. Arithmetic is done at width `W`+1 to detect the sign.
- Waypoints: `WP1` (220,75), `WP2` (220,240), `WP3` (440,240).
  - A phase change retargets immediately; the boss moves from its current position, with no jump.
- `arrived` is registered: it is 1 in the cycle after pos equals the active target.
- Outputs are all registered.
- Reset values: `bossx` = 0, `bossy` = 75 (spawn point), `boss` = 0, `phase` = 0, `arrived` = 0, `flash` = 0, divider counter = 0.

## Timing
- Spawn: `boss` rises 1 cycle after the spawn condition is sampled true.
- Phase change: `phase` updates 1 cycle after `bosshp` crosses a threshold.
- Move tick:
  - A divider counter runs 0..`MOVE_DIV`−1 and ticks on wrap.
  - It is cleared on IDLE → P1, so the first move occurs `MOVE_DIV` cycles after `boss` rises.
  - With `MOVE_DIV` = 1, the boss moves every cycle.
- If a tick and a phase change occur in the same cycle, the step is taken toward the *new* phase target.
- If `rst` is asserted mid-motion, all outputs return to their reset values immediately (asynchronous).

## Configuration
- `BOSS_FLASH_EN` defined:
  - Registers the previous `bosshp`. When the boss is active and `bosshp` < previous value, `flash` = 1 for `FLASH_CYC` cycles.
  - A new hit during a flash restarts the count.
  - DEAD clears `flash`.
- `BOSS_FLASH_EN` not defined: no HP history or flash counter is built; `flash` is constant 0.

## Structure
- Package `boss_pkg` holds:
  - the state enum (IDLE, P1, P2, P3, DEAD);
  - `SPAWN_X`/`SPAWN_Y`;
  - the `WP1`–`WP3` coordinate constants;
  - the phase encoding.
- Sub-module `boss_axis_step` (parameters `W`, `STEP`): takes pos, target and tick, and outputs next_pos and at_target. It is instantiated twice, once for x and once for y.

## Test plan
- HP=450, `enm`=4'b0010, then `enm`=0 → `boss`=1 and `phase`=1 one cycle later, position (0,75). HP=451 with `enm`=0 → remains IDLE.
- P1 with `MOVE_DIV`=1, `STEP`=1 → `bossx` reaches 220 after 220 ticks and stops; `arrived`=1 the following cycle.
- At (220,75), HP drops 301 → 300 → `phase`=2 next cycle; `bossy` climbs to 240 and stops.
- In P1, HP jumps 400 → 100 → `phase`=3 directly; a later HP of 400 keeps `phase`=3.
- `STEP`=7, `MOVE_DIV`=3, target 220 from 0 → moves every 3 cycles: …, 210, 217, 220 with no overshoot. Assert `rst` mid-motion → (0,75), `boss`=0 immediately.
- With `BOSS_FLASH_EN`, HP 300 → 290 → `flash`=1 for 8 cycles. A second hit at cycle 5 extends the flash to 8 cycles after that hit. HP → 0 gives DEAD with `flash`=0 and `boss`=0.
